// File: rtl/lvds_rx_pkg.sv
// Shared types and defaults for the LVDS receive word aligner.
package lvds_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    HUNT,
    SLIP,
    SETTLE,
    LOCKED
  } lvds_align_state_t;

  localparam int LVDS_DESER_W = 4;
  localparam logic [LVDS_DESER_W-1:0] LVDS_TRAIN_PATTERN = 4'b1100;

  // A counter that must be able to hold its terminal value.
  function automatic int lvds_cnt_w(input int terminal);
    return $clog2(terminal) + 1;
  endfunction

endpackage

// File: rtl/lvds_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module lvds_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/lvds_rx_word_aligner.sv
// Word aligner: hunts for the training word by pulsing bit-slip, then forwards framed words.
// Optional statistics outputs are enabled with LVDS_RX_ALIGN_STATS_EN.
module lvds_rx_word_aligner
  import lvds_rx_pkg::*;
#(
  parameter int                 DESER_W       = LVDS_DESER_W,
  parameter logic [DESER_W-1:0] TRAIN_PATTERN = DESER_W'(LVDS_TRAIN_PATTERN),
  parameter int                 MATCH_COUNT   = 8,
  parameter int                 SLIP_SETTLE   = 4,
  parameter int                 LOSS_COUNT    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic [DESER_W-1:0] rx_data,
  input  logic               train_en,
  output logic               rx_bitslip,
  output logic               aligned,
  output logic [DESER_W-1:0] data_out,
  output logic               data_valid,
  output logic               align_wrap,
  output lvds_align_state_t  o_dbg_state
`ifdef LVDS_RX_ALIGN_STATS_EN
  ,
  output logic [15:0]        slip_total,
  output logic [7:0]         loss_events
`endif
);

  localparam int MATCH_CW  = lvds_cnt_w(MATCH_COUNT);
  localparam int SLIP_CW   = lvds_cnt_w(DESER_W);
  localparam int LOSS_CW   = lvds_cnt_w(LOSS_COUNT);
  localparam int SETTLE_CW = lvds_cnt_w(SLIP_SETTLE);

  localparam logic [MATCH_CW-1:0]  MATCH_LAST  = MATCH_CW'(MATCH_COUNT - 1);
  localparam logic [MATCH_CW-1:0]  MATCH_TOP   = MATCH_CW'(MATCH_COUNT);
  localparam logic [SLIP_CW-1:0]   SLIP_LAST   = SLIP_CW'(DESER_W - 1);
  localparam logic [LOSS_CW-1:0]   LOSS_LAST   = LOSS_CW'(LOSS_COUNT - 1);
  localparam logic [SETTLE_CW-1:0] SETTLE_LAST = SETTLE_CW'(SLIP_SETTLE - 1);

  logic w_lock_s;

  lvds_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (pll_locked),
    .o_sync  (w_lock_s)
  );

  lvds_align_state_t r_state;
  lvds_align_state_t w_state_next;
  logic [MATCH_CW-1:0]  r_match_cnt,  w_match_next;
  logic [SLIP_CW-1:0]   r_slip_cnt,   w_slip_next;
  logic [LOSS_CW-1:0]   r_loss_cnt,   w_loss_next;
  logic [SETTLE_CW-1:0] r_settle_cnt, w_settle_next;

  logic w_hit;
  logic w_enter_slip;
  logic w_wrap;
  logic w_stay_locked;

  logic               r_bitslip;
  logic               r_aligned;
  logic [DESER_W-1:0] r_data_out;
  logic               r_data_valid;
  logic               r_align_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_LOCK;
      r_match_cnt  <= '0;
      r_slip_cnt   <= '0;
      r_loss_cnt   <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_match_cnt  <= w_match_next;
      r_slip_cnt   <= w_slip_next;
      r_loss_cnt   <= w_loss_next;
      r_settle_cnt <= w_settle_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_match_next  = r_match_cnt;
    w_slip_next   = r_slip_cnt;
    w_loss_next   = r_loss_cnt;
    w_settle_next = r_settle_cnt;
    w_hit         = (rx_data == TRAIN_PATTERN);

    unique case (r_state)
      WAIT_LOCK: begin
        w_match_next = '0;
        w_slip_next  = '0;
        w_loss_next  = '0;
        if (w_lock_s) w_state_next = HUNT;
      end
      HUNT: begin
        if (w_hit) begin
          if (r_match_cnt >= MATCH_LAST) begin
            w_match_next = MATCH_TOP;
            w_state_next = LOCKED;
          end else begin
            w_match_next = r_match_cnt + MATCH_CW'(1);
          end
        end else begin
          // slip_cnt advances as SLIP is entered so align_wrap lines up with rx_bitslip
          w_match_next = '0;
          w_slip_next  = (r_slip_cnt == SLIP_LAST) ? '0 : r_slip_cnt + SLIP_CW'(1);
          w_state_next = SLIP;
        end
      end
      SLIP: begin
        w_settle_next = '0;
        w_state_next  = SETTLE;
      end
      SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_match_next = '0;
          w_state_next = HUNT;
        end else begin
          w_settle_next = r_settle_cnt + SETTLE_CW'(1);
        end
      end
      LOCKED: begin
        if (train_en) begin
          if (w_hit) begin
            w_loss_next = '0;
          end else if (r_loss_cnt >= LOSS_LAST) begin
            w_loss_next  = '0;
            w_match_next = '0;
            w_state_next = HUNT;
          end else begin
            w_loss_next = r_loss_cnt + LOSS_CW'(1);
          end
        end
      end
      default: w_state_next = WAIT_LOCK;
    endcase

    // Losing PLL lock overrides everything, including a slip about to be issued.
    if (!w_lock_s) begin
      w_state_next = WAIT_LOCK;
      w_match_next = '0;
      w_slip_next  = '0;
      w_loss_next  = '0;
    end
  end

  assign w_enter_slip  = (r_state == HUNT) && (w_state_next == SLIP);
  assign w_wrap        = w_enter_slip && (r_slip_cnt == SLIP_LAST);
  assign w_stay_locked = (r_state == LOCKED) && (w_state_next == LOCKED);

  // data_valid qualifies data_out in the same cycle: high only for payload words while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitslip    <= 1'b0;
      r_aligned    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_align_wrap <= 1'b0;
    end else begin
      r_bitslip    <= w_enter_slip;
      r_aligned    <= (w_state_next == LOCKED);
      r_data_out   <= w_stay_locked ? rx_data : '0;
      r_data_valid <= w_stay_locked && !train_en;
      r_align_wrap <= w_wrap;
    end
  end

  assign rx_bitslip  = r_bitslip;
  assign aligned     = r_aligned;
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign align_wrap  = r_align_wrap;
  assign o_dbg_state = r_state;

`ifdef LVDS_RX_ALIGN_STATS_EN
  logic [15:0] r_slip_total;
  logic [7:0]  r_loss_events;

  // Statistics survive PLL lock loss; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slip_total  <= '0;
      r_loss_events <= '0;
    end else begin
      if (w_enter_slip && (r_slip_total != 16'hFFFF))
        r_slip_total <= r_slip_total + 16'd1;
      if ((r_state == LOCKED) && (w_state_next == HUNT) && (r_loss_events != 8'hFF))
        r_loss_events <= r_loss_events + 8'd1;
    end
  end

  assign slip_total  = r_slip_total;
  assign loss_events = r_loss_events;
`endif

endmodule
